// File: rtl/busmux_pkg.sv
// rtl/busmux_pkg.sv - shared bus source/destination code space
package busmux_pkg;

    localparam int NUM_SRC = 24;

    localparam logic [4:0] CODE_R0     = 5'd0;
    localparam logic [4:0] CODE_R15    = 5'd15;
    localparam logic [4:0] CODE_HI     = 5'd16;
    localparam logic [4:0] CODE_LO     = 5'd17;
    localparam logic [4:0] CODE_ZHI    = 5'd18;
    localparam logic [4:0] CODE_ZLO    = 5'd19;
    localparam logic [4:0] CODE_PC     = 5'd20;
    localparam logic [4:0] CODE_MDR    = 5'd21;
    localparam logic [4:0] CODE_INPORT = 5'd22;
    localparam logic [4:0] CODE_C      = 5'd23;

    // Bits 0-17 (R0-R15, HI, LO), 20 (PC) and 21 (MDR) may be written from the bus.
    localparam logic [NUM_SRC-1:0] WRITABLE_MASK = 24'h33_FFFF;

endpackage

// File: rtl/busdemux_decoder.sv
// rtl/busdemux_decoder.sv - destination code to one-hot write strobe plus legal flag
module busdemux_decoder
    import busmux_pkg::*;
(
    input  logic [4:0]         code,
    output logic [NUM_SRC-1:0] onehot,
    output logic               legal
);

    logic [NUM_SRC-1:0] raw;

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            raw[i] = (code == 5'(i));
        end
    end

    // Codes 24-31 never match any bit, so they fall out as illegal too.
    assign onehot = raw & WRITABLE_MASK;
    assign legal  = |onehot;

endmodule

// File: rtl/busdemux_regbank.sv
// rtl/busdemux_regbank.sv - bus write demux with two-stage commit into the register bank
module busdemux_regbank
    import busmux_pkg::*;
#(
    parameter int DW      = 32,
    parameter bit R0_ZERO = 1'b1,
    parameter int PC_STEP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW-1:0]      bus_in,
    input  logic [4:0]         wr_dest,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               commit_hold,
    input  logic               pc_inc,
    output logic [16*DW-1:0]   gpr_q,
    output logic [DW-1:0]      hi_q,
    output logic [DW-1:0]      lo_q,
    output logic [DW-1:0]      pc_q,
    output logic [NUM_SRC-1:0] ld_en,
    output logic [DW-1:0]      ld_data,
    output logic               err,
    output logic [4:0]         err_code
);

    logic                 s_v;
    logic [DW-1:0]        s_data;
    logic [4:0]           s_dest;
    logic [NUM_SRC-1:0]   dec_onehot;
    logic                 dec_legal;
    logic [15:0][DW-1:0]  gpr;
    logic                 accept;
    logic                 commit;

    assign wr_ready = !s_v || !commit_hold;
    assign accept   = wr_valid && wr_ready;
    assign commit   = s_v && !commit_hold;

    busdemux_decoder u_dec (
        .code   (s_dest),
        .onehot (dec_onehot),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_v    <= 1'b0;
            s_data <= '0;
            s_dest <= '0;
        end else if (accept) begin
            s_v    <= 1'b1;
            s_data <= bus_in;
            s_dest <= wr_dest;
        end else if (commit) begin
            s_v    <= 1'b0;
        end
    end

    // ld_data keeps the last legal value; illegal commits only touch err/err_code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_en    <= '0;
            ld_data  <= '0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            ld_en <= '0;
            err   <= 1'b0;
            if (commit) begin
                ld_en <= dec_onehot;
                if (dec_legal) begin
                    ld_data <= s_data;
                end else begin
                    err      <= 1'b1;
                    err_code <= s_dest;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            for (int i = 0; i < 16; i++) begin
                if (dec_onehot[i] && !(i == 0 && R0_ZERO)) begin
                    gpr[i] <= s_data;
                end
            end
            if (dec_onehot[CODE_HI]) hi_q <= s_data;
            if (dec_onehot[CODE_LO]) lo_q <= s_data;
        end
    end

    // A bus write to PC wins over the increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (commit && dec_onehot[CODE_PC]) begin
            pc_q <= s_data;
        end else if (pc_inc) begin
            pc_q <= pc_q + DW'(PC_STEP);
        end
    end

    assign gpr_q = gpr;

endmodule

// File: tb/tb_busdemux_regbank.sv
// tb/tb_busdemux_regbank.sv - scoreboard bench for busdemux_regbank
module tb_busdemux_regbank;

    typedef struct packed {
        logic [23:0] en;
        logic [31:0] data;
        logic        err;
        logic [4:0]  code;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   bus_in;
    logic [4:0]    wr_dest;
    logic          wr_valid;
    logic          wr_ready;
    logic          commit_hold;
    logic          pc_inc;
    logic [511:0]  gpr_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   pc_q;
    logic [23:0]   ld_en;
    logic [31:0]   ld_data;
    logic          err;
    logic [4:0]    err_code;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    busdemux_regbank #(.DW(32), .R0_ZERO(1'b1), .PC_STEP(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_in      (bus_in),
        .wr_dest     (wr_dest),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .commit_hold (commit_hold),
        .pc_inc      (pc_inc),
        .gpr_q       (gpr_q),
        .hi_q        (hi_q),
        .lo_q        (lo_q),
        .pc_q        (pc_q),
        .ld_en       (ld_en),
        .ld_data     (ld_data),
        .err         (err),
        .err_code    (err_code)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] gpr(input int i);
        return gpr_q[i*32 +: 32];
    endfunction

    // Present a write and hold it until accepted; pushes the expected strobe when push=1.
    task automatic write(input logic [31:0] d, input logic [4:0] c, input bit push);
        exp_t e;
        bit   legal;
        int   waited;
        bus_in   = d;
        wr_dest  = c;
        wr_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!wr_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!wr_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=wr_ready_low required=accept dest=%0d", c);
        end
        legal  = (c <= 5'd17) || (c == 5'd20) || (c == 5'd21);
        e.en   = legal ? (24'd1 << c) : 24'd0;
        e.data = d;
        e.err  = !legal;
        e.code = c;
        @(posedge clk);
        if (push) exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every strobe or error pulse the DUT presents must match the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (ld_en != 24'd0 || err)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual=ld_en:%0h err:%0b required=none", ld_en, err);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_ld_en", ld_en, e.en);
                    chk("sb_err", err, e.err);
                    if (e.err) chk("sb_err_code", err_code, e.code);
                    else       chk("sb_ld_data", ld_data, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; bus_in = '0; wr_dest = '0; wr_valid = 1'b0;
        commit_hold = 1'b0; pc_inc = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_ld_en", ld_en, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_gpr", gpr_q, 0);
        chk("rst_pc", pc_q, 0);

        // Single write, one-cycle latency, no bypass
        @(posedge clk); #1;
        write(32'hDEAD_BEEF, 5'd5, 1);
        wr_valid = 1'b0;
        @(negedge clk);
        chk("r5_before_commit", gpr(5), 32'h0);
        @(negedge clk);
        chk("r5_after_commit", gpr_q, {320'd0, 32'hDEAD_BEEF, 160'd0});
        chk("hi_untouched", hi_q, 0);
        chk("lo_untouched", lo_q, 0);

        // R0 discard and external MDR
        @(posedge clk); #1;
        write(32'h1234, 5'd0, 1);
        write(32'h55, 5'd21, 1);
        idle(3);
        chk("r0_zero", gpr(0), 32'h0);
        chk("gpr_after_mdr", gpr_q, {320'd0, 32'hDEAD_BEEF, 160'd0});
        chk("ld_data_holds", ld_data, 32'h55);
        chk("pc_after_mdr", pc_q, 0);

        // HI / LO
        @(posedge clk); #1;
        write(32'hAAAA_0001, 5'd16, 1);
        write(32'hBBBB_0002, 5'd17, 1);
        idle(3);
        chk("hi_write", hi_q, 32'hAAAA_0001);
        chk("lo_write", lo_q, 32'hBBBB_0002);

        // Illegal destinations
        @(posedge clk); #1;
        write(32'h1111, 5'd18, 1);
        chk("illegal_no_stall", wr_ready, 1);
        write(32'h2222, 5'd27, 1);
        chk("illegal_no_stall2", wr_ready, 1);
        idle(3);
        chk("err_code_sticky", err_code, 5'd27);
        chk("illegal_gpr", gpr_q, {320'd0, 32'hDEAD_BEEF, 160'd0});
        chk("illegal_ld_data", ld_data, 32'hBBBB_0002);

        // PC wrap, then bus write beats pc_inc
        @(posedge clk); #1;
        write(32'hFFFF_FFFC, 5'd20, 1);
        idle(2);
        chk("pc_loaded", pc_q, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        pc_inc = 1'b1;
        @(posedge clk); #1;
        pc_inc = 1'b0;
        chk("pc_wrap", pc_q, 32'h0);
        write(32'h100, 5'd20, 1);
        wr_valid = 1'b0;
        pc_inc   = 1'b1;
        @(posedge clk); #1;
        pc_inc = 1'b0;
        chk("pc_bus_priority", pc_q, 32'h100);
        idle(2);

        // Commit hold with back-to-back writes
        @(posedge clk); #1;
        write(32'd1, 5'd1, 1);
        commit_hold = 1'b1;
        bus_in = 32'd2; wr_dest = 5'd2; wr_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("hold_wr_ready", wr_ready, 0);
            chk("hold_r1", gpr(1), 0);
            chk("hold_r2", gpr(2), 0);
            @(posedge clk); #1;
        end
        commit_hold = 1'b0;
        write(32'd2, 5'd2, 1);
        write(32'd3, 5'd3, 1);
        idle(3);
        chk("hold_r1_final", gpr(1), 32'd1);
        chk("hold_r2_final", gpr(2), 32'd2);
        chk("hold_r3_final", gpr(3), 32'd3);

        // Reset while a dest-7 write is pending
        @(posedge clk); #1;
        write(32'h7777, 5'd7, 0);
        wr_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_r7", gpr(7), 0);
        chk("rst_mid_gpr", gpr_q, 0);
        chk("rst_mid_wr_ready", wr_ready, 1);
        chk("rst_mid_pc", pc_q, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/busdemux_regbank.md
Name: busdemux_regbank

Overview:
- Write-side counterpart of the bus multiplexer: takes a 32-bit value from the shared bus plus a 5-bit destination code, and commits the value to the addressed register.
- Uses the same 5-bit code space as the bus-source select. Codes 0-15 are R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C.
- Holds R0-R15, HI, LO and PC internally. Emits one-cycle load-enable strobes so external registers (MDR) can capture the bus.
- Sits between the datapath bus and the register storage; driven by the control unit.

Parameters:
- DW, 32, data width of bus and registers.
- R0_ZERO, 1, when 1 writes to R0 are discarded and R0 always reads 0.
- PC_STEP, 4, increment applied by pc_inc.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- bus_in  input  DW  value on the shared bus.
- wr_dest  input  5  destination code.
- wr_valid  input  1  write request.
- wr_ready  output  1  block can accept a write this cycle.
- commit_hold  input  1  freezes the commit stage.
- pc_inc  input  1  advance PC by PC_STEP.
- gpr_q  output  16*DW  R0-R15 flattened, R0 in the LSBs.
- hi_q  output  DW  HI register.
- lo_q  output  DW  LO register.
- pc_q  output  DW  PC register.
- ld_en  output  24  one-hot commit strobe, bit index = destination code.
- ld_data  output  DW  data accompanying ld_en.
- err  output  1  one-cycle pulse on an illegal destination.
- err_code  output  5  last illegal code, sticky.

Behaviour:
- Reset (async assert, sync release): all of the following are 0: every register, ld_en, ld_data, err, err_code, and the internal stage valid s_v.
- Reset mid-operation discards any pending write.
- wr_ready = !s_v || !commit_hold. It is 1 out of reset.
- Stage 1 (accept): when wr_valid && wr_ready, capture bus_in into s_data, wr_dest into s_dest, and set s_v=1.
- Stage 2 (commit): on the next edge with s_v && !commit_hold, commit and clear s_v. If a new write is accepted in the same cycle, s_v stays 1 and holds the new entry.
- Latency: accept at edge N, visible on the register output after edge N+1.
- Back-to-back writes sustain 1 per cycle while commit_hold=0.
- While commit_hold=1 with s_v=1: wr_ready=0, the stage holds its contents, and no strobes are issued.
- Legal destinations: 0-17, 20, 21.
  - 0-15 write GPRs; R0 is skipped when R0_ZERO=1, but ld_en[0] still pulses.
  - 16 writes HI, 17 writes LO, 20 writes PC.
  - 21 (MDR) is external: ld_en[21] pulses only.
- Illegal destinations: 18, 19, 22, 23, 24-31.
  - No register changes and ld_en stays 0.
  - err pulses for 1 cycle and err_code latches the code.
  - The write is still consumed, with no stall.
- ld_en and ld_data are registered. ld_en is a 1-cycle pulse coincident with the register update, and ld_data equals the committed value.
- ld_data holds its value between commits.
- PC priority:
  - A bus commit to PC overrides pc_inc in the same cycle.
  - Otherwise pc_inc adds PC_STEP modulo 2^DW, so 0xFFFFFFFC+4 wraps to 0.
  - pc_inc is independent of commit_hold.
- Only one destination is written per commit. There is no read-during-write bypass; outputs show the old value until the commit edge.

Decomposition:
- Shared package busmux_pkg:
  - localparams for the 24 destination/source codes (CODE_R0..CODE_C).
  - NUM_SRC=24.
  - Writable-code mask constant.
  - This package is shared with the bus-source encoder and the mux.
- Sub-module busdemux_decoder, combinational:
  - 5-bit code -> 24-bit one-hot plus legal flag.
  - Instantiated once, on s_dest.

Test Plan:
- Reset, then write 0xDEADBEEF to dest 5 -> ld_en[5] pulses 1 cycle after the accept edge; gpr_q R5=0xDEADBEEF; all other registers stay 0.
- Write 0x1234 to dest 0 with R0_ZERO=1 -> R0 stays 0 and ld_en[0] pulses. Write 0x55 to dest 21 -> ld_en[21] pulses, ld_data=0x55, no internal register changes.
- Write to dest 18, then 27 -> err pulses twice, err_code=27, no ld_en and no register change, wr_ready stays 1.
- PC=0xFFFFFFFC with pc_inc=1 -> PC=0. Same-cycle commit of 0x100 to dest 20 plus pc_inc -> PC=0x100.
- Writes R1=1, R2=2, R3=3 on consecutive cycles with commit_hold asserted for 2 cycles after the first accept:
  - wr_ready=0 while held.
  - R2 is not committed during the hold.
  - All three registers end with the correct values and none are lost or duplicated.
- Assert rst_n low while s_v=1 for dest 7 -> R7 stays 0, no ld_en after release, wr_ready=1.
